// File: rtl/tpu_result_drain_pkg.sv
// Shared TPU definitions for the result drain: state encoding, default
// accumulator width and the row/column index width convention.
package tpu_result_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } drain_state_t;

    localparam int ACC_W_DEFAULT = 32;

    // Same index width rule the controller uses for load_row.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tpu_result_drain_if.sv
// Valid/ready element stream from the result drain towards the host buffer.
interface tpu_result_drain_if
    import tpu_result_drain_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
);
    logic             valid;
    logic             ready;
    logic [ACC_W-1:0] data;
    logic             last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tpu_row_serializer.sv
// Buffers one accumulator row and streams its columns out on valid/ready.
module tpu_row_serializer
    import tpu_result_drain_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 send,
    input  logic                 last_row,
    input  logic [N*ACC_W-1:0]   row_data,
    output logic                 row_done,
    tpu_result_drain_if.master   m
);
    localparam int CW = idx_w(N);
    localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

    logic [N*ACC_W-1:0] row_buf;
    logic [CW-1:0]      col;
    logic               fire;

    assign fire     = send & m.ready;
    assign row_done = fire && (col == LAST_COL);

    // The buffer is the only copy of the row once FETCH ends, so the array
    // upstream is free to be reused while we are still streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf <= '0;
            col     <= '0;
        end else if (load) begin
            row_buf <= row_data;
            col     <= '0;
        end else if (fire && (col != LAST_COL)) begin
            col <= col + 1'b1;
        end
    end

    assign m.valid = send;
    assign m.data  = row_buf[int'(col)*ACC_W +: ACC_W];
    assign m.last  = send && last_row && (col == LAST_COL);

endmodule

// File: rtl/tpu_result_drain.sv
// Drains the accumulator array row by row after the controller's done edge,
// streaming every element out and flagging done edges that arrive too early.
module tpu_result_drain
    import tpu_result_drain_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 done,
    output logic [$clog2(N)-1:0] acc_row_sel,
    input  logic [N*ACC_W-1:0]   acc_row_data,
    tpu_result_drain_if.master   m,
    output logic                 busy,
    output logic                 drain_done,
    output logic                 overrun
);
    localparam int RW = idx_w(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    drain_state_t  state, state_next;
    logic [RW-1:0] row, row_next;
    logic          done_q;
    logic          trigger;
    logic          row_done;

    // done_q resets high so a done level left over from before reset is not
    // mistaken for a fresh completion.
    assign trigger = done & ~done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row     <= '0;
            done_q  <= 1'b1;
            overrun <= 1'b0;
        end else begin
            state  <= state_next;
            row    <= row_next;
            done_q <= done;
            if (trigger && (state != IDLE))
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    row_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = SEND;
            SEND: begin
                if (row_done) begin
                    if (row != LAST_ROW) begin
                        row_next   = row + 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                drain_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // row only moves on entry to FETCH, so it doubles as the held select.
    assign acc_row_sel = row;
    assign busy        = (state != IDLE);

    tpu_row_serializer #(
        .N     (N),
        .ACC_W (ACC_W)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == FETCH),
        .send     (state == SEND),
        .last_row (row == LAST_ROW),
        .row_data (acc_row_data),
        .row_done (row_done),
        .m        (m)
    );

endmodule

// File: tb/tb_tpu_result_drain.sv
// Self-checking bench for tpu_result_drain with N=4, ACC_W=32.
module tb_tpu_result_drain;
    localparam int N     = 4;
    localparam int ACC_W = 32;

    typedef struct {
        logic        done;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
        logic        exp_busy;
        logic        exp_dd;
        logic [1:0]  exp_sel;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               done;
    logic [1:0]         acc_row_sel;
    logic [N*ACC_W-1:0] acc_row_data;
    logic               busy;
    logic               drain_done;
    logic               overrun;
    logic [31:0]        mem [N][N];

    int total_checks  = 0;
    int passed_checks = 0;
    vec_t vecs [22];

    tpu_result_drain_if #(.ACC_W(ACC_W)) m_if ();

    tpu_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .done         (done),
        .acc_row_sel  (acc_row_sel),
        .acc_row_data (acc_row_data),
        .m            (m_if),
        .busy         (busy),
        .drain_done   (drain_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational model of the accumulator array read port.
    always_comb begin
        acc_row_data = '0;
        for (int c = 0; c < N; c++)
            acc_row_data[c*ACC_W +: ACC_W] = mem[acc_row_sel][c];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input vec_t v);
        done = v.done;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " acc_row_sel"}, 32'(acc_row_sel), 32'd0);
        check_output({tag, " m_valid"}, 32'(m_if.valid), 32'd0);
        check_output({tag, " m_data"}, m_if.data, 32'd0);
        check_output({tag, " m_last"}, 32'(m_if.last), 32'd0);
        check_output({tag, " busy"}, 32'(busy), 32'd0);
        check_output({tag, " drain_done"}, 32'(drain_done), 32'd0);
        check_output({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    // Creates a done rising edge, then scoreboards the whole drain against mem.
    task automatic run_drain(input string tag, input bit rand_ready, input int glitch_at);
        int          idx;
        int          first_valid;
        bit          stalled;
        bit          seen_dd;
        logic [31:0] prev_data;
        logic        prev_last;
        idx = 0; first_valid = -1; stalled = 1'b0; seen_dd = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        m_if.ready = 1'b1;
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        for (int n = 1; n <= 300 && !seen_dd; n++) begin
            @(negedge clk);
            if (n == glitch_at)     done = 1'b0;
            if (n == glitch_at + 1) done = 1'b1;
            if (stalled) begin
                check_output({tag, " stall data"}, m_if.data, prev_data);
                check_output({tag, " stall last"}, 32'(m_if.last), 32'(prev_last));
            end
            if (m_if.valid && first_valid < 0) first_valid = n;
            if (drain_done) seen_dd = 1'b1;
            m_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = m_if.valid && !m_if.ready;
            prev_data = m_if.data;
            prev_last = m_if.last;
            if (m_if.valid && m_if.ready) begin
                if (idx < N*N) begin
                    check_output({tag, " data"}, m_if.data, mem[idx/N][idx%N]);
                    check_output({tag, " last"}, 32'(m_if.last), 32'(idx == N*N-1));
                end
                idx++;
            end
        end
        m_if.ready = 1'b1;
        check_output({tag, " drain_done seen"}, 32'(seen_dd), 32'd1);
        check_output({tag, " element count"}, 32'(idx), 32'(N*N));
        check_output({tag, " first valid cycle"}, 32'(first_valid), 32'd2);
        @(negedge clk);
        check_output({tag, " drain_done pulse"}, 32'(drain_done), 32'd0);
        check_output({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        bit found;

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mem[r][c] = 32'(100*r + c);

        // Expected cycle-by-cycle view of one drain with m_ready held high.
        for (int i = 0; i < 22; i++) begin
            vecs[i].done      = 1'b1;
            vecs[i].exp_valid = 1'b0;
            vecs[i].exp_data  = '0;
            vecs[i].exp_last  = 1'b0;
            vecs[i].exp_busy  = (i < 21);
            vecs[i].exp_dd    = (i == 20);
            vecs[i].exp_sel   = (i < 20) ? 2'(i / 5) : 2'd3;
            if (i < 20 && (i % 5) != 0) begin
                vecs[i].exp_valid = 1'b1;
                vecs[i].exp_data  = 32'(100*(i/5) + (i%5) - 1);
                vecs[i].exp_last  = (i == 19);
            end
        end

        rst = 1'b1; done = 1'b0; m_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d valid", i), 32'(m_if.valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("vec%0d data", i), m_if.data, vecs[i].exp_data);
                check_output($sformatf("vec%0d last", i), 32'(m_if.last), 32'(vecs[i].exp_last));
            end
            check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d drain_done", i), 32'(drain_done), 32'(vecs[i].exp_dd));
            check_output($sformatf("vec%0d acc_row_sel", i), 32'(acc_row_sel), 32'(vecs[i].exp_sel));
        end

        // done stays high: no second drain may start.
        busy_cycles = 0;
        repeat (180) begin
            @(negedge clk);
            if (busy || drain_done) busy_cycles++;
        end
        check_output("sticky done busy cycles", 32'(busy_cycles), 32'd0);
        check_output("overrun after clean drain", 32'(overrun), 32'd0);

        run_drain("backpressure", 1'b1, -1);

        mem[0][0] = 32'h8000_0000;
        mem[0][1] = 32'h7FFF_FFFF;
        mem[0][2] = 32'hFFFF_FFFF;
        mem[0][3] = 32'h0000_0000;
        run_drain("signed", 1'b0, -1);
        check_output("overrun before glitch", 32'(overrun), 32'd0);

        run_drain("glitch", 1'b0, 8);
        check_output("overrun after glitch", 32'(overrun), 32'd1);
        run_drain("second drain", 1'b1, -1);
        check_output("overrun sticky", 32'(overrun), 32'd1);

        // Reset in the middle of row 2.
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (m_if.valid && acc_row_sel == 2'd2) found = 1'b1;
        end
        check_output("reach row 2", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("mid-drain reset");
        rst = 1'b0;
        busy_cycles = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy || m_if.valid || drain_done) busy_cycles++;
        end
        check_output("stale done after reset", 32'(busy_cycles), 32'd0);

        rst = 1'b1; done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_drain("post-reset", 1'b0, -1);
        check_output("overrun post-reset", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
